// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem address, IF/ID register with stall, redirect flush
// and an optional halt-word stop compiled in with FETCH_HALT_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic [15:0] imem_data,
    output logic [15:0] imem_addr,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic        ir_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

`ifdef FETCH_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ir_pc_q, ir_pc_d;
    logic        ir_valid_q, ir_valid_d;
    logic        halted_q, halted_d;
    logic [15:0] fetch_count_q, fetch_count_d;

    // Next-state: redirect beats halt hold, which beats stall, which beats capture.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ir_d          = ir_q;
        ir_pc_d       = ir_pc_q;
        ir_valid_d    = ir_valid_q;
        halted_d      = halted_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            pc_d       = redirect_target & 16'hFFFE;
            ir_valid_d = 1'b0;
            state_d    = ST_FETCH;
            halted_d   = 1'b0;
        end else if (state_q == ST_HALTED) begin
            ir_valid_d = 1'b0;
        end else if (!stall) begin
            ir_d          = imem_data;
            ir_pc_d       = pc_q;
            ir_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 16'd1;
            // A halt word is still delivered, but the PC parks on it.
            if (HaltEn && (imem_data == HALT_WORD)) begin
                state_d  = ST_HALTED;
                halted_d = 1'b1;
            end else begin
                pc_d = pc_q + 16'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            ir_q          <= 16'h0000;
            ir_pc_q       <= 16'h0000;
            ir_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ir_pc_q       <= ir_pc_d;
            ir_valid_q    <= ir_valid_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign ir          = ir_q;
    assign ir_pc       = ir_pc_q;
    assign ir_valid    = ir_valid_q;
    assign halted      = HaltEn & halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; expectations follow FETCH_HALT_EN when defined.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        ir_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int total = 0;
    int bad   = 0;

`ifdef FETCH_HALT_EN
    localparam bit HaltEn = 1'b1;
`else
    localparam bit HaltEn = 1'b0;
`endif

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .imem_data      (imem_data),
        .imem_addr      (imem_addr),
        .ir             (ir),
        .ir_pc          (ir_pc),
        .ir_valid       (ir_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'h3112;
            16'h0002: mem_word = 16'h3413;
            16'h0004: mem_word = 16'h0140;
            16'h0006: mem_word = 16'hFFFF;
            default:  mem_word = 16'h1000 | {4'h0, a[11:0]};
        endcase
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 16'h1234;
        tick();
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL rst_pc got=%h exp=0000", imem_addr); end
        total++; if (ir !== 16'h0000) begin bad++; $display("FAIL rst_ir got=%h exp=0000", ir); end
        total++; if (ir_pc !== 16'h0000) begin bad++; $display("FAIL rst_ir_pc got=%h exp=0000", ir_pc); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ir_valid); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b exp=0", halted); end
        total++; if (fetch_count !== 16'h0000) begin bad++; $display("FAIL rst_count got=%h exp=0000", fetch_count); end
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
    endtask

    task automatic test_sequential();
        logic [15:0] exp_ir [3] = '{16'h3112, 16'h3413, 16'h0140};
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ir !== exp_ir[i]) begin bad++; $display("FAIL seq_ir[%0d] got=%h exp=%h", i, ir, exp_ir[i]); end
            total++; if (ir_pc !== 16'(2 * i)) begin bad++; $display("FAIL seq_ir_pc[%0d] got=%h exp=%h", i, ir_pc, 16'(2 * i)); end
            total++; if (fetch_count !== 16'(i + 1)) begin bad++; $display("FAIL seq_count[%0d] got=%0d exp=%0d", i, fetch_count, i + 1); end
            total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, ir_valid); end
        end
    endtask

    task automatic test_stall();
        reset = 1'b1; tick(); reset = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (imem_addr !== 16'h0002) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=0002", i, imem_addr); end
            total++; if (ir !== 16'h3112) begin bad++; $display("FAIL stall_ir[%0d] got=%h exp=3112", i, ir); end
            total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, ir_valid); end
            total++; if (fetch_count !== 16'd1) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=1", i, fetch_count); end
        end
        stall = 1'b0;
        tick();
        total++; if (ir !== 16'h3413) begin bad++; $display("FAIL stall_rel_ir got=%h exp=3413", ir); end
        total++; if (ir_pc !== 16'h0002) begin bad++; $display("FAIL stall_rel_ir_pc got=%h exp=0002", ir_pc); end
        total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL stall_rel_count got=%0d exp=2", fetch_count); end
        // stalled bubble right after reset
        reset = 1'b1; tick(); reset = 1'b0; stall = 1'b1;
        tick();
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%b exp=0", ir_valid); end
        total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL bubble_count got=%0d exp=0", fetch_count); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL bubble_addr got=%h exp=0000", imem_addr); end
        stall = 1'b0;
    endtask

    task automatic test_redirect();
        tick(); tick();
        stall = 1'b1; tick();
        redirect_valid = 1'b1; redirect_target = 16'h0021;
        tick();
        total++; if (imem_addr !== 16'h0020) begin bad++; $display("FAIL redir_addr got=%h exp=0020", imem_addr); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got=%b exp=0", ir_valid); end
        total++; if (ir !== 16'h3413) begin bad++; $display("FAIL redir_ir_hold got=%h exp=3413", ir); end
        total++; if (ir_pc !== 16'h0002) begin bad++; $display("FAIL redir_ir_pc_hold got=%h exp=0002", ir_pc); end
        total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL redir_count got=%0d exp=2", fetch_count); end
        redirect_valid = 1'b0; stall = 1'b0;
        tick();
        total++; if (ir_pc !== 16'h0020) begin bad++; $display("FAIL redir_cap_ir_pc got=%h exp=0020", ir_pc); end
        total++; if (ir !== 16'h1020) begin bad++; $display("FAIL redir_cap_ir got=%h exp=1020", ir); end
        total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL redir_cap_valid got=%b exp=1", ir_valid); end
        total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL redir_cap_count got=%0d exp=3", fetch_count); end
        total++; if (imem_addr !== 16'h0022) begin bad++; $display("FAIL redir_cap_addr got=%h exp=0022", imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 16'hFFFE) begin bad++; $display("FAIL wrap_addr got=%h exp=fffe", imem_addr); end
        tick();
        total++; if (ir_pc !== 16'hFFFE) begin bad++; $display("FAIL wrap_ir_pc0 got=%h exp=fffe", ir_pc); end
        total++; if (ir !== 16'h1FFE) begin bad++; $display("FAIL wrap_ir0 got=%h exp=1ffe", ir); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0000", imem_addr); end
        tick();
        total++; if (ir_pc !== 16'h0000) begin bad++; $display("FAIL wrap_ir_pc1 got=%h exp=0000", ir_pc); end
        total++; if (ir !== 16'h3112) begin bad++; $display("FAIL wrap_ir1 got=%h exp=3112", ir); end
    endtask

    task automatic test_halt();
        logic [15:0] exp_addr;
        exp_addr = HaltEn ? 16'h0006 : 16'h0008;
        reset = 1'b1; tick(); reset = 1'b0;
        repeat (4) tick();
        total++; if (ir !== 16'hFFFF) begin bad++; $display("FAIL halt_ir got=%h exp=ffff", ir); end
        total++; if (ir_valid !== 1'b1) begin bad++; $display("FAIL halt_valid got=%b exp=1", ir_valid); end
        total++; if (fetch_count !== 16'd4) begin bad++; $display("FAIL halt_count got=%0d exp=4", fetch_count); end
        total++; if (halted !== HaltEn) begin bad++; $display("FAIL halt_flag got=%b exp=%b", halted, HaltEn); end
        total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL halt_addr got=%h exp=%h", imem_addr, exp_addr); end
        // HALTED ignores stall and drops valid; without halt the stall just holds
        stall = 1'b1;
        tick();
        total++; if (ir_valid !== !HaltEn) begin bad++; $display("FAIL halt_next_valid got=%b exp=%b", ir_valid, !HaltEn); end
        total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL halt_next_addr got=%h exp=%h", imem_addr, exp_addr); end
        total++; if (ir !== 16'hFFFF) begin bad++; $display("FAIL halt_next_ir got=%h exp=ffff", ir); end
        total++; if (fetch_count !== 16'd4) begin bad++; $display("FAIL halt_next_count got=%0d exp=4", fetch_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0; stall = 1'b0;
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL hrst_pc got=%h exp=0000", imem_addr); end
        total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL hrst_count got=%0d exp=0", fetch_count); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL hrst_halted got=%b exp=0", halted); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL hrst_valid got=%b exp=0", ir_valid); end
        total++; if (ir !== 16'h0000) begin bad++; $display("FAIL hrst_ir got=%h exp=0000", ir); end
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_target = 16'h0000;
        tick();
        redirect_valid = 1'b0;
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL hredir_halted got=%b exp=0", halted); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL hredir_addr got=%h exp=0000", imem_addr); end
        total++; if (ir_valid !== 1'b0) begin bad++; $display("FAIL hredir_valid got=%b exp=0", ir_valid); end
        tick();
        total++; if (ir_pc !== 16'h0000) begin bad++; $display("FAIL hredir_cap_ir_pc got=%h exp=0000", ir_pc); end
        total++; if (ir !== 16'h3112) begin bad++; $display("FAIL hredir_cap_ir got=%h exp=3112", ir); end
        total++; if (fetch_count !== 16'd5) begin bad++; $display("FAIL hredir_cap_count got=%0d exp=5", fetch_count); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 16'h0000;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
